// File: rtl/soc_store_ctrl.sv
// soc_store_ctrl: in-order store queue that turns M-stage stores into aligned, strobed bus writes
module soc_store_ctrl #(
    parameter logic [1:0] XLEN  = 2'd2,
    parameter int         DEPTH = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_clk_en,
    input  logic                              i_sw_m,
    input  logic [(1<<(int'(XLEN)+4))-1:0]    i_mem_data_m,
    input  logic [(1<<(int'(XLEN)+4))-1:0]    i_mem_addr_m,
    input  logic                              i_store_byte_m,
    input  logic                              i_store_half_m,
    output logic                              o_stall,
    output logic                              o_misalign,
    output logic                              o_busy,
    output logic                              o_bus_req,
    output logic [(1<<(int'(XLEN)+4))-1:0]    o_bus_addr,
    output logic [(1<<(int'(XLEN)+4))-1:0]    o_bus_wdata,
    output logic [(1<<(int'(XLEN)+4))/8-1:0]  o_bus_wstrb,
    input  logic                              i_bus_ack
);
    localparam int DW = 1 << (int'(XLEN) + 4);
    localparam int SB = DW / 8;
    localparam int OW = $clog2(SB);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t          state;
    logic [PW-1:0]   wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0]   count, cnt_nxt;
    logic [DW-1:0]   q_addr  [DEPTH];
    logic [DW-1:0]   q_wdata [DEPTH];
    logic [SB-1:0]   q_wstrb [DEPTH];
    logic [OW-1:0]   off;
    logic            full, is_half, aligned, push, pop, mis, bypass;
    logic [DW-1:0]   new_addr, new_wdata, nxt_addr, nxt_wdata;
    logic [SB-1:0]   new_wstrb, nxt_wstrb;

    // Lane encoding of the incoming store and push/pop decisions
    always_comb begin
        off       = i_mem_addr_m[OW-1:0];
        is_half   = i_store_half_m & ~i_store_byte_m;
        aligned   = i_store_byte_m | (is_half ? ~off[0] : (off == '0));
        full      = count == CW'(DEPTH);
        push      = i_clk_en & i_sw_m & ~full & aligned;
        mis       = i_clk_en & i_sw_m & ~full & ~aligned;
        pop       = (state == REQ) & i_bus_ack;
        new_addr  = {i_mem_addr_m[DW-1:OW], {OW{1'b0}}};
        new_wstrb = i_store_byte_m ? SB'(1) << off : is_half ? SB'(3) << off : '1;
        new_wdata = i_store_byte_m ? DW'(i_mem_data_m[7:0]) << {off, 3'b000}
                  : is_half ? DW'(i_mem_data_m[15:0]) << {off, 3'b000} : i_mem_data_m;
        cnt_nxt   = count + CW'(push) - CW'(pop);
        rd_nxt    = rd_ptr + PW'(1);
        bypass    = (count == CW'(1)) & push;
        nxt_addr  = bypass ? new_addr  : q_addr[rd_nxt];
        nxt_wdata = bypass ? new_wdata : q_wdata[rd_nxt];
        nxt_wstrb = bypass ? new_wstrb : q_wstrb[rd_nxt];
    end

    // Queue storage, written at the tail on every accepted store
    always_ff @(posedge i_clk) begin
        if (push) begin
            q_addr[wr_ptr]  <= new_addr;
            q_wdata[wr_ptr] <= new_wdata;
            q_wstrb[wr_ptr] <= new_wstrb;
        end
    end

    // Pointers, occupancy, misalign pulse and the bus request FSM with registered bus outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_misalign  <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
            o_bus_wstrb <= '0;
        end else begin
            o_misalign <= mis;
            count      <= cnt_nxt;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (state == IDLE) begin
                if (count != '0) begin
                    state       <= REQ;
                    o_bus_addr  <= q_addr[rd_ptr];
                    o_bus_wdata <= q_wdata[rd_ptr];
                    o_bus_wstrb <= q_wstrb[rd_ptr];
                end
            end else if (i_bus_ack) begin
                rd_ptr <= rd_nxt;
                if (cnt_nxt != '0) begin
                    o_bus_addr  <= nxt_addr;
                    o_bus_wdata <= nxt_wdata;
                    o_bus_wstrb <= nxt_wstrb;
                end else begin
                    state       <= IDLE;
                    o_bus_addr  <= '0;
                    o_bus_wdata <= '0;
                    o_bus_wstrb <= '0;
                end
            end
        end
    end

    assign o_bus_req = state == REQ;
    assign o_stall   = i_sw_m & full;
    assign o_busy    = (count != '0) | (state == REQ);
endmodule

// File: tb/tb_soc_store_ctrl.sv
// tb_soc_store_ctrl: scoreboard bench for the store sequencer with directed stores
module tb_soc_store_ctrl;
    logic        clk = 1'b0, rst = 1'b1, clk_en = 1'b1, sw = 1'b0, sb = 1'b0, sh = 1'b0, ack = 1'b0;
    logic [63:0] data = '0, addr = '0;
    logic        stall, misalign, busy, req;
    logic [63:0] bus_addr, bus_wdata;
    logic [7:0]  bus_wstrb;
    int          vecs = 0, errs = 0;
    logic [135:0] exp_q[$];

    soc_store_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_sw_m(sw),
        .i_mem_data_m(data), .i_mem_addr_m(addr),
        .i_store_byte_m(sb), .i_store_half_m(sh),
        .o_stall(stall), .o_misalign(misalign), .o_busy(busy),
        .o_bus_req(req), .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
        .o_bus_wstrb(bus_wstrb), .i_bus_ack(ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "timeout");
    end

    // Monitor: every accepted bus write is popped against the scoreboard
    always @(negedge clk) begin
        if (!rst && req && ack) begin
            vecs++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL bus_wr unexpected act=%h/%h/%h exp=none", bus_addr, bus_wdata, bus_wstrb);
            end else begin
                logic [135:0] e;
                e = exp_q.pop_front();
                if ({bus_addr, bus_wdata, bus_wstrb} !== e) begin
                    errs++;
                    $display("FAIL bus_wr act=%h/%h/%h exp=%h/%h/%h", bus_addr, bus_wdata, bus_wstrb,
                             e[135:72], e[71:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        exp_q.push_back({a, d, s});
    endtask

    task automatic store(input logic [63:0] a, input logic [63:0] d, input logic b, input logic h);
        sw = 1'b1; addr = a; data = d; sb = b; sh = h;
        @(posedge clk); #1;
        sw = 1'b0; sb = 1'b0; sh = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        ack = 1'b1;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ack = 1'b0;
        chk("drain_idle", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {63'd0, req}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mis", {63'd0, misalign}, 64'd0);
        chk("rst_addr", bus_addr, 64'd0);
        chk("rst_strb", {56'd0, bus_wstrb}, 64'd0);
        rst = 1'b0;

        expect_wr(64'h1000, 64'hDEAD_BEEF_0123_4567, 8'hFF);
        store(64'h1000, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0);
        chk("lat_req_e", {63'd0, req}, 64'd0);
        chk("lat_busy_e", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        chk("lat_req_e1", {63'd0, req}, 64'd1);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        chk("ack_req", {63'd0, req}, 64'd0);
        chk("ack_busy", {63'd0, busy}, 64'd0);
        chk("idle_wdata", bus_wdata, 64'd0);

        expect_wr(64'h1000, 64'h0000_AB00_0000_0000, 8'h20);
        store(64'h1005, 64'hAB, 1'b1, 1'b0);
        drain();

        store(64'h1003, 64'h1234, 1'b0, 1'b1);
        chk("mis_pulse", {63'd0, misalign}, 64'd1);
        chk("mis_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        chk("mis_clear", {63'd0, misalign}, 64'd0);
        chk("mis_noreq", {63'd0, req}, 64'd0);

        clk_en = 1'b0;
        store(64'h1008, 64'h99, 1'b0, 1'b0);
        clk_en = 1'b1;
        chk("clken_hold", {63'd0, busy}, 64'd0);

        expect_wr(64'h2000, 64'h1111_2222_3333_4444, 8'hFF);
        expect_wr(64'h2000, 64'h0000_0000_0000_5A00, 8'h02);
        expect_wr(64'h2000, 64'hBEEF_0000_0000_0000, 8'hC0);
        expect_wr(64'h2000, 64'h0000_0000_5678_0000, 8'h0C);
        store(64'h2000, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        store(64'h2001, 64'h5A, 1'b1, 1'b0);
        store(64'h2006, 64'hBEEF, 1'b0, 1'b1);
        store(64'h2002, 64'h1234_5678, 1'b0, 1'b1);
        sw = 1'b1; addr = 64'h2007; data = 64'hCD; sb = 1'b1; sh = 1'b1;
        #1;
        chk("full_stall", {63'd0, stall}, 64'd1);
        @(posedge clk); #1;
        chk("full_refused", {63'd0, stall}, 64'd1);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        chk("stall_drop", {63'd0, stall}, 64'd0);
        expect_wr(64'h2000, 64'hCD00_0000_0000_0000, 8'h80);
        @(posedge clk); #1;
        chk("refill_stall", {63'd0, stall}, 64'd1);
        sw = 1'b0; sb = 1'b0; sh = 1'b0;
        drain();

        expect_wr(64'h3008, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
        expect_wr(64'h3008, 64'h7700_0000_0000_0000, 8'h80);
        expect_wr(64'h3010, 64'h0000_0000_0000_1234, 8'h03);
        store(64'h3008, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0);
        store(64'h300F, 64'h77, 1'b1, 1'b0);
        store(64'h3010, 64'h1234, 1'b0, 1'b1);
        chk("b2b_req0", {63'd0, req}, 64'd1);
        ack = 1'b1;
        @(posedge clk); #1;
        chk("b2b_req1", {63'd0, req}, 64'd1);
        @(posedge clk); #1;
        chk("b2b_req2", {63'd0, req}, 64'd1);
        @(posedge clk); #1;
        ack = 1'b0;
        chk("b2b_idle", {63'd0, req}, 64'd0);
        chk("b2b_busy", {63'd0, busy}, 64'd0);

        store(64'h4000, 64'h1, 1'b0, 1'b0);
        store(64'h4008, 64'h2, 1'b0, 1'b0);
        chk("rst_mid_req", {63'd0, req}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstm_req", {63'd0, req}, 64'd0);
        chk("rstm_busy", {63'd0, busy}, 64'd0);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        chk("late_ack_req", {63'd0, req}, 64'd0);
        chk("late_ack_busy", {63'd0, busy}, 64'd0);

        expect_wr(64'h5000, 64'h55, 8'hFF);
        store(64'h5000, 64'h55, 1'b0, 1'b0);
        drain();

        @(posedge clk); #1;
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
